// File: rtl/cb_pkg.sv
// rtl/cb_pkg.sv - shared types for the cross-bar master request path
// Purpose : FSM state encoding, command encoding and the master-id type
//           used by master_arbiter and rr_arb2.
// Ports   : none (package)
package cb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic {
    MST_1 = 1'b0,
    MST_2 = 1'b1
  } mst_id_t;

endpackage

// File: rtl/master_arbiter_rr_arb2.sv
// rtl/master_arbiter_rr_arb2.sv - two-input round-robin winner select
// Purpose : combinational winner = f(req_1, req_2, last_gnt).
// Ports   : req_1_i, req_2_i   - request lines of master 1 / master 2
//           last_gnt_i         - master that won the previous grant
//           winner_o           - selected master (only meaningful if a req is set)
module rr_arb2
  import cb_pkg::*;
(
  input  logic    req_1_i,
  input  logic    req_2_i,
  input  mst_id_t last_gnt_i,
  output mst_id_t winner_o
);

  always_comb begin
    winner_o = MST_1;
    if (req_1_i && req_2_i) begin
      // contended: the master that did not win last time goes next
      winner_o = (last_gnt_i == MST_1) ? MST_2 : MST_1;
    end else if (req_2_i) begin
      winner_o = MST_2;
    end
  end

endmodule

// File: rtl/master_arbiter.sv
// rtl/master_arbiter.sv - two-master round-robin arbiter for the cross-bar request path
// Purpose : merges two master request channels into one slave request, holds
//           the grant until slave_ack or timeout, steers ack/rdata back to
//           the granted master only.
// Ports   : clk, rst (sync, active-low)
//           master_{1,2}_req/addr/cmd/wdata in, master_{1,2}_ack/rdata out
//           slave_req/addr/cmd/wdata out, slave_ack/rdata in
//           timeout out (one-cycle abort pulse, coincident with master ack)
module master_arbiter
  import cb_pkg::*;
#(
  parameter int N              = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         master_1_req,
  input  logic [N-1:0] master_1_addr,
  input  logic         master_1_cmd,
  input  logic [N-1:0] master_1_wdata,
  output logic         master_1_ack,
  output logic [N-1:0] master_1_rdata,
  input  logic         master_2_req,
  input  logic [N-1:0] master_2_addr,
  input  logic         master_2_cmd,
  input  logic [N-1:0] master_2_wdata,
  output logic         master_2_ack,
  output logic [N-1:0] master_2_rdata,
  output logic         slave_req,
  output logic [N-1:0] slave_addr,
  output logic         slave_cmd,
  output logic [N-1:0] slave_wdata,
  input  logic         slave_ack,
  input  logic [N-1:0] slave_rdata,
  output logic         timeout
);

  // a zero timeout still needs a 1-bit counter to keep the widths legal
  localparam int          CW      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state_q, state_d;
  mst_id_t       gnt_q, gnt_d;
  mst_id_t       last_gnt_q, last_gnt_d;
  mst_id_t       winner;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          slave_req_q, slave_req_d;
  logic [N-1:0]  slave_addr_q, slave_addr_d;
  logic          slave_cmd_q, slave_cmd_d;
  logic [N-1:0]  slave_wdata_q, slave_wdata_d;
  logic          m1_ack_q, m1_ack_d, m2_ack_q, m2_ack_d;
  logic [N-1:0]  m1_rdata_q, m1_rdata_d, m2_rdata_q, m2_rdata_d;
  logic          timeout_q, timeout_d;

  rr_arb2 u_rr_arb2 (
    .req_1_i    (master_1_req),
    .req_2_i    (master_2_req),
    .last_gnt_i (last_gnt_q),
    .winner_o   (winner)
  );

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      gnt_q         <= MST_1;
      last_gnt_q    <= MST_2;
      cnt_q         <= '0;
      slave_req_q   <= 1'b0;
      slave_addr_q  <= '0;
      slave_cmd_q   <= CMD_READ;
      slave_wdata_q <= '0;
      m1_ack_q      <= 1'b0;
      m2_ack_q      <= 1'b0;
      m1_rdata_q    <= '0;
      m2_rdata_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      last_gnt_q    <= last_gnt_d;
      cnt_q         <= cnt_d;
      slave_req_q   <= slave_req_d;
      slave_addr_q  <= slave_addr_d;
      slave_cmd_q   <= slave_cmd_d;
      slave_wdata_q <= slave_wdata_d;
      m1_ack_q      <= m1_ack_d;
      m2_ack_q      <= m2_ack_d;
      m1_rdata_q    <= m1_rdata_d;
      m2_rdata_q    <= m2_rdata_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_gnt_d    = last_gnt_q;
    cnt_d         = cnt_q;
    slave_req_d   = slave_req_q;
    slave_addr_d  = slave_addr_q;
    slave_cmd_d   = slave_cmd_q;
    slave_wdata_d = slave_wdata_q;
    m1_ack_d      = m1_ack_q;
    m2_ack_d      = m2_ack_q;
    m1_rdata_d    = m1_rdata_q;
    m2_rdata_d    = m2_rdata_q;
    timeout_d     = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (master_1_req || master_2_req) begin
          gnt_d       = winner;
          last_gnt_d  = winner;
          slave_req_d = 1'b1;
          cnt_d       = '0;
          state_d     = BUSY;
          if (winner == MST_1) begin
            slave_addr_d  = master_1_addr;
            slave_cmd_d   = master_1_cmd;
            slave_wdata_d = master_1_wdata;
          end else begin
            slave_addr_d  = master_2_addr;
            slave_cmd_d   = master_2_cmd;
            slave_wdata_d = master_2_wdata;
          end
        end
      end

      BUSY: begin
        // slave_ack is checked first so it beats a timeout in the same cycle
        if (slave_ack) begin
          slave_req_d = 1'b0;
          state_d     = RESP;
          if (gnt_q == MST_1) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = slave_rdata;
          end else begin
            m2_ack_d   = 1'b1;
            m2_rdata_d = slave_rdata;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TO_VAL)) begin
          // this BUSY cycle is the TIMEOUT_CYCLES-th one without an ack
          slave_req_d = 1'b0;
          timeout_d   = 1'b1;
          state_d     = RESP;
          if (gnt_q == MST_1) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = '0;
          end else begin
            m2_ack_d   = 1'b1;
            m2_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RESP: begin
        // rdata returns to 0 so it is only non-zero while ack is high
        m1_ack_d   = 1'b0;
        m2_ack_d   = 1'b0;
        m1_rdata_d = '0;
        m2_rdata_d = '0;
        timeout_d  = 1'b0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign master_1_ack   = m1_ack_q;
  assign master_1_rdata = m1_rdata_q;
  assign master_2_ack   = m2_ack_q;
  assign master_2_rdata = m2_rdata_q;
  assign slave_req      = slave_req_q;
  assign slave_addr     = slave_addr_q;
  assign slave_cmd      = slave_cmd_q;
  assign slave_wdata    = slave_wdata_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_master_arbiter.sv
// tb/tb_master_arbiter.sv - self-checking bench for master_arbiter
module tb_master_arbiter;
  import cb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        master_1_req = 1'b0, master_1_cmd = 1'b0;
  logic [31:0] master_1_addr = '0, master_1_wdata = '0;
  logic        master_2_req = 1'b0, master_2_cmd = 1'b0;
  logic [31:0] master_2_addr = '0, master_2_wdata = '0;
  logic        master_1_ack, master_2_ack;
  logic [31:0] master_1_rdata, master_2_rdata;
  logic        slave_req, slave_cmd, timeout;
  logic [31:0] slave_addr, slave_wdata;
  logic        slave_ack = 1'b0;
  logic [31:0] slave_rdata = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  master_arbiter #(.N(32), .TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .master_1_req   (master_1_req),
    .master_1_addr  (master_1_addr),
    .master_1_cmd   (master_1_cmd),
    .master_1_wdata (master_1_wdata),
    .master_1_ack   (master_1_ack),
    .master_1_rdata (master_1_rdata),
    .master_2_req   (master_2_req),
    .master_2_addr  (master_2_addr),
    .master_2_cmd   (master_2_cmd),
    .master_2_wdata (master_2_wdata),
    .master_2_ack   (master_2_ack),
    .master_2_rdata (master_2_rdata),
    .slave_req      (slave_req),
    .slave_addr     (slave_addr),
    .slave_cmd      (slave_cmd),
    .slave_wdata    (slave_wdata),
    .slave_ack      (slave_ack),
    .slave_rdata    (slave_rdata),
    .timeout        (timeout)
  );

  typedef struct {
    mst_id_t     m;
    logic [31:0] rd;
    logic        to;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        r1;
    logic [31:0] a1;
    logic        c1;
    logic [31:0] w1;
    logic        r2;
    logic [31:0] a2;
    logic        c2;
    logic [31:0] w2;
    int          dly;
    logic [31:0] rd1;
    logic [31:0] rd2;
  } vec_t;
  vec_t vt[5];

  mst_id_t model_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mst_id_t rr_model(input logic r1, input logic r2, input mst_id_t last);
    if (r1 && r2) return (last == MST_1) ? MST_2 : MST_1;
    if (r2) return MST_2;
    return MST_1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Ack checker: every master ack must match the oldest expected completion.
  always @(negedge clk) begin
    if (master_1_ack || master_2_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, master_2_ack, master_1_ack}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack1", 32'(master_1_ack), 32'(e.m == MST_1));
        chk("ack2", 32'(master_2_ack), 32'(e.m == MST_2));
        chk("rdata", (e.m == MST_1) ? master_1_rdata : master_2_rdata, e.rd);
        chk("other_rdata", (e.m == MST_1) ? master_2_rdata : master_1_rdata, 32'd0);
        chk("timeout_flag", 32'(timeout), 32'(e.to));
      end
    end else begin
      chk("quiet_timeout", 32'(timeout), 32'd0);
      chk("quiet_rdata", master_1_rdata | master_2_rdata, 32'd0);
    end
  end

  // Waits for the grant, checks captured fields, holds slave_req busy for
  // dly cycles with slave_ack in the last one. Returns at the RESP negedge.
  task automatic serve(input int dly, input logic [31:0] rd, input logic [31:0] ea,
                       input logic ec, input logic [31:0] ew, output time t_gnt);
    for (int n = 0; n < 12 && !slave_req; n++) tick();
    chk("grant_seen", 32'(slave_req), 32'd1);
    t_gnt = $time;
    chk("slave_addr", slave_addr, ea);
    chk("slave_cmd", 32'(slave_cmd), 32'(ec));
    chk("slave_wdata", slave_wdata, ew);
    for (int i = 1; i < dly; i++) begin
      tick();
      chk("sreq_held", 32'(slave_req), 32'd1);
      chk("addr_frozen", slave_addr, ea);
    end
    slave_ack   = 1'b1;
    slave_rdata = rd;
    tick();
    slave_ack   = 1'b0;
    slave_rdata = '0;
    chk("sreq_drop", 32'(slave_req), 32'd0);
  endtask

  initial begin
    time t_g, t_prev;
    logic p1, p2;
    mst_id_t w;

    vt[0] = '{1'b1, 32'h0000_0100, CMD_READ, 32'h0, 1'b1, 32'h8000_0004, CMD_WRITE, 32'h1234_5678,
              1, 32'h1111_0001, 32'h2222_0002};
    vt[1] = '{1'b1, 32'h0000_0010, CMD_READ, 32'h0, 1'b0, 32'h0, CMD_READ, 32'h0,
              2, 32'hA5A5_0001, 32'h0};
    vt[2] = '{1'b0, 32'h0, CMD_READ, 32'h0, 1'b1, 32'h0000_0020, CMD_READ, 32'h0,
              3, 32'h0, 32'h3333_0003};
    vt[3] = '{1'b1, 32'h0000_0044, CMD_WRITE, 32'hDEAD_BEEF, 1'b1, 32'h0000_0048, CMD_READ, 32'h0,
              2, 32'h4444_0004, 32'h5555_0005};
    vt[4] = '{1'b1, 32'h0000_0050, CMD_READ, 32'h0, 1'b1, 32'h0000_0054, CMD_WRITE, 32'h0BAD_F00D,
              1, 32'h6666_0006, 32'h7777_0007};

    // reset state
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_sreq", 32'(slave_req), 32'd0);
    chk("rst_saddr", slave_addr, 32'd0);
    chk("rst_swdata", slave_wdata, 32'd0);
    chk("rst_acks", {30'd0, master_2_ack, master_1_ack}, 32'd0);
    rst = 1'b1;
    model_last = MST_2;
    tick();

    // table-driven episodes: run until every requesting master is served
    for (int v = 0; v < 5; v++) begin
      master_1_addr = vt[v].a1; master_1_cmd = vt[v].c1; master_1_wdata = vt[v].w1;
      master_2_addr = vt[v].a2; master_2_cmd = vt[v].c2; master_2_wdata = vt[v].w2;
      master_1_req  = vt[v].r1; master_2_req = vt[v].r2;
      p1 = vt[v].r1; p2 = vt[v].r2;
      while (p1 || p2) begin
        w = rr_model(p1, p2, model_last);
        model_last = w;
        sb.push_back('{w, (w == MST_1) ? vt[v].rd1 : vt[v].rd2, 1'b0});
        if (w == MST_1) begin
          serve(vt[v].dly, vt[v].rd1, vt[v].a1, vt[v].c1, vt[v].w1, t_g);
          master_1_req = 1'b0; p1 = 1'b0;
        end else begin
          serve(vt[v].dly, vt[v].rd2, vt[v].a2, vt[v].c2, vt[v].w2, t_g);
          master_2_req = 1'b0; p2 = 1'b0;
        end
      end
      tick();
    end

    // both masters hold req for 6 transactions with immediate ack
    master_1_addr = 32'h0000_1000; master_1_cmd = CMD_READ;  master_1_wdata = 32'h0;
    master_2_addr = 32'h0000_2000; master_2_cmd = CMD_WRITE; master_2_wdata = 32'h0000_2222;
    master_1_req = 1'b1; master_2_req = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 6; i++) begin
      w = rr_model(1'b1, 1'b1, model_last);
      model_last = w;
      sb.push_back('{w, 32'hC0DE_0000 + 32'(i), 1'b0});
      if (w == MST_1) serve(1, 32'hC0DE_0000 + 32'(i), 32'h0000_1000, CMD_READ, 32'h0, t_g);
      else            serve(1, 32'hC0DE_0000 + 32'(i), 32'h0000_2000, CMD_WRITE, 32'h0000_2222, t_g);
      if (i > 0) chk("rr_period", 32'(t_g - t_prev), 32'd30);
      t_prev = t_g;
    end
    master_1_req = 1'b0; master_2_req = 1'b0;
    tick();
    tick();

    // timeout: 4 BUSY cycles without ack, then a stray ack
    master_1_addr = 32'h0000_0070; master_1_cmd = CMD_READ;
    master_1_req = 1'b1;
    model_last = MST_1;
    sb.push_back('{MST_1, 32'h0, 1'b1});
    for (int n = 0; n < 12 && !slave_req; n++) tick();
    chk("to_grant", 32'(slave_req), 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("to_busy", 32'(slave_req), 32'd1);
    end
    tick();
    chk("to_sreq_drop", 32'(slave_req), 32'd0);
    chk("to_pulse", 32'(timeout), 32'd1);
    master_1_req = 1'b0;
    slave_ack = 1'b1; slave_rdata = 32'hBAD0_BAD0;
    tick();
    slave_ack = 1'b0; slave_rdata = '0;
    chk("stray_ack", {30'd0, master_2_ack, master_1_ack}, 32'd0);
    tick();
    chk("stray_ack2", {30'd0, master_2_ack, master_1_ack}, 32'd0);
    chk("stray_sreq", 32'(slave_req), 32'd0);

    // slave_ack in the exact cycle the timeout would expire
    master_2_addr = 32'h0000_0090; master_2_cmd = CMD_READ; master_2_wdata = 32'h0;
    master_2_req = 1'b1;
    model_last = MST_2;
    sb.push_back('{MST_2, 32'h9999_0009, 1'b0});
    serve(4, 32'h9999_0009, 32'h0000_0090, CMD_READ, 32'h0, t_g);
    master_2_req = 1'b0;
    tick();

    // reset during BUSY
    master_1_addr = 32'h0000_00A0; master_1_req = 1'b1;
    for (int n = 0; n < 12 && !slave_req; n++) tick();
    chk("rb_grant", 32'(slave_req), 32'd1);
    rst = 1'b0;
    tick();
    master_1_req = 1'b0;
    chk("rb_sreq", 32'(slave_req), 32'd0);
    chk("rb_saddr", slave_addr, 32'd0);
    chk("rb_acks", {30'd0, master_2_ack, master_1_ack}, 32'd0);
    rst = 1'b1;
    model_last = MST_2;
    tick();
    tick();
    chk("rb_idle", 32'(slave_req), 32'd0);
    master_1_addr = 32'h0000_00B0; master_1_cmd = CMD_WRITE; master_1_wdata = 32'h0000_B0B0;
    master_2_addr = 32'h0000_00C0; master_2_cmd = CMD_READ;  master_2_wdata = 32'h0;
    master_1_req = 1'b1; master_2_req = 1'b1;
    w = rr_model(1'b1, 1'b1, model_last);
    model_last = w;
    sb.push_back('{w, 32'hB0B0_0001, 1'b0});
    serve(1, 32'hB0B0_0001, 32'h0000_00B0, CMD_WRITE, 32'h0000_B0B0, t_g);
    master_1_req = 1'b0; master_2_req = 1'b0;
    tick();
    tick();
    tick();
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1);
  end

endmodule
